lut_eval_sweep: RTL and testbench

- Parametrised boolean-function unit: N_FN independent functions of N_IN shared inputs, each held as a runtime-writable truth table (2**N_IN bits).
- Evaluation path: valid/ready handshake, one registered output stage with backpressure.
- Optional sweep engine walks all 2**N_IN input codes and streams every table row, so truth-table checks run in hardware.
- Generalises the team's fixed 4-input SOP functions.

---
 rtl/lut_eval_pkg.sv | 20 ++
 rtl/lut_bank.sv | 49 ++++
 rtl/lut_eval_sweep.sv | 176 +++++++++++++++++
 tb/tb_lut_eval_sweep.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_eval_pkg.sv
// Shared types and constants for the LUT evaluation unit and its truth-table sweep engine.
package lut_eval_pkg;

  localparam int N_IN_DEFAULT = 4;
  localparam int N_FN_DEFAULT = 2;

  // Reference table: minterms 2,3,4,5,10,11,13,15.
  localparam logic [15:0] TT_Q01 = 16'hAC3C;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sweep_state_e;

  function automatic int fn_sel_w(input int n_fn);
    return (n_fn > 1) ? $clog2(n_fn) : 1;
  endfunction

endpackage

// File: rtl/lut_bank.sv
// Truth-table storage: one TT_W-bit table per function, one write port and two
// combinational read ports (evaluation and sweep). The sweep port can be compiled out.
module lut_bank
  import lut_eval_pkg::*;
#(
  parameter int N_IN    = N_IN_DEFAULT,
  parameter int N_FN    = N_FN_DEFAULT,
  parameter bit RD_B_EN = 1'b1,
  localparam int TT_W   = 1 << N_IN,
  localparam int FN_W   = fn_sel_w(N_FN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [FN_W-1:0] wr_fn,
  input  logic [TT_W-1:0] wr_tt,
  input  logic [N_IN-1:0] rd_a_x,
  output logic [N_FN-1:0] rd_a_s,
  input  logic [N_IN-1:0] rd_b_x,
  output logic [N_FN-1:0] rd_b_s
);

  // An out-of-range wr_fn matches no table, so the write simply disappears.
  for (genvar gi = 0; gi < N_FN; gi++) begin : g_fn
    logic [TT_W-1:0] tt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tt_q <= '0;
      end else if (we && (wr_fn == FN_W'(gi))) begin
        tt_q <= wr_tt;
      end
    end

    assign rd_a_s[gi] = tt_q[rd_a_x];

    if (RD_B_EN) begin : g_rd_b
      assign rd_b_s[gi] = tt_q[rd_b_x];
    end else begin : g_no_rd_b
      assign rd_b_s[gi] = 1'b0;
    end
  end

  if (!RD_B_EN) begin : g_rd_b_off
    logic unused_rd_b;
    assign unused_rd_b = ^rd_b_x;
  end

endmodule

// File: rtl/lut_eval_sweep.sv
// Runtime-programmable N_FN x N_IN boolean function unit with a registered eval stage.
// Build option LUT_SWEEP_EN adds the exhaustive truth-table sweep engine.
module lut_eval_sweep
  import lut_eval_pkg::*;
#(
  parameter int N_IN  = N_IN_DEFAULT,
  parameter int N_FN  = N_FN_DEFAULT,
  localparam int TT_W = 1 << N_IN,
  localparam int FN_W = fn_sel_w(N_FN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_we,
  input  logic [FN_W-1:0] cfg_fn,
  input  logic [TT_W-1:0] cfg_tt,
  output logic            cfg_ready,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_x,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N_FN-1:0] out_s,
  input  logic            sweep_start,
  output logic            sweep_busy,
  output logic            sweep_valid,
  output logic [N_IN-1:0] sweep_idx,
  output logic [N_FN-1:0] sweep_s,
  output logic            sweep_done
);

`ifdef LUT_SWEEP_EN
  localparam bit SWEEP_EN = 1'b1;
`else
  localparam bit SWEEP_EN = 1'b0;
`endif

  logic [N_FN-1:0] eval_s;
  logic [N_FN-1:0] sweep_rd_s;
  logic [N_IN-1:0] sweep_rd_x;
  logic            cfg_wr_en;

  assign cfg_wr_en = cfg_we && cfg_ready;

  lut_bank #(
    .N_IN    (N_IN),
    .N_FN    (N_FN),
    .RD_B_EN (SWEEP_EN)
  ) u_bank (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (cfg_wr_en),
    .wr_fn  (cfg_fn),
    .wr_tt  (cfg_tt),
    .rd_a_x (in_x),
    .rd_a_s (eval_s),
    .rd_b_x (sweep_rd_x),
    .rd_b_s (sweep_rd_s)
  );

  // ---------------------------------------------------------------- eval stage
  logic            out_valid_q, out_valid_d;
  logic [N_FN-1:0] out_s_q, out_s_d;
  logic            in_accept;

  assign in_ready  = !out_valid_q || out_ready;
  assign in_accept = in_valid && in_ready;

  // The lookup uses the table as it stands before this edge, so a write in the
  // accept cycle only affects later requests.
  always_comb begin
    out_valid_d = out_valid_q;
    out_s_d     = out_s_q;
    if (in_accept) begin
      out_valid_d = 1'b1;
      out_s_d     = eval_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_s_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_s_q     <= out_s_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_s     = out_s_q;

  // ---------------------------------------------------------------- sweep engine
`ifdef LUT_SWEEP_EN
  localparam logic [N_IN:0] LAST_IDX = (N_IN + 1)'(TT_W - 1);

  sweep_state_e    state_q, state_d;
  logic [N_IN:0]   idx_q, idx_d;
  logic            sweep_valid_q, sweep_valid_d;
  logic [N_IN-1:0] sweep_idx_q, sweep_idx_d;
  logic [N_FN-1:0] sweep_s_q, sweep_s_d;
  logic            sweep_done_q, sweep_done_d;

  assign sweep_rd_x = idx_q[N_IN-1:0];

  // Rows trail the FSM by one register stage; the done pulse is visible while
  // the FSM already sits in IDLE, so a start is held off until it has passed.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    sweep_valid_d = 1'b0;
    sweep_idx_d   = '0;
    sweep_s_d     = '0;
    sweep_done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sweep_start && !sweep_done_q) begin
          state_d = RUN;
          idx_d   = '0;
        end
      end
      RUN: begin
        sweep_valid_d = 1'b1;
        sweep_idx_d   = idx_q[N_IN-1:0];
        sweep_s_d     = sweep_rd_s;
        idx_d         = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end
      end
      DONE: begin
        sweep_done_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      sweep_valid_q <= 1'b0;
      sweep_idx_q   <= '0;
      sweep_s_q     <= '0;
      sweep_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      sweep_valid_q <= sweep_valid_d;
      sweep_idx_q   <= sweep_idx_d;
      sweep_s_q     <= sweep_s_d;
      sweep_done_q  <= sweep_done_d;
    end
  end

  assign sweep_busy  = (state_q != IDLE) || sweep_done_q;
  assign sweep_valid = sweep_valid_q;
  assign sweep_idx   = sweep_idx_q;
  assign sweep_s     = sweep_s_q;
  assign sweep_done  = sweep_done_q;
  assign cfg_ready   = !sweep_busy;
`else
  logic unused_sweep;
  assign unused_sweep = ^{sweep_start, sweep_rd_s};
  assign sweep_rd_x   = '0;
  assign sweep_busy   = 1'b0;
  assign sweep_valid  = 1'b0;
  assign sweep_idx    = '0;
  assign sweep_s      = '0;
  assign sweep_done   = 1'b0;
  assign cfg_ready    = 1'b1;
`endif

endmodule

// File: tb/tb_lut_eval_sweep.sv
// Self-checking bench for lut_eval_sweep: behavioural model + per-cycle compare,
// directed scenarios and randomized traffic. Honours LUT_SWEEP_EN like the design.
module tb_lut_eval_sweep;
  import lut_eval_pkg::*;

  localparam int N_IN = 4;
  localparam int N_FN = 2;
  localparam int TT_W = 16;
  localparam int FN_W = 1;
`ifdef LUT_SWEEP_EN
  localparam bit SW_EN = 1'b1;
`else
  localparam bit SW_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            cfg_we = 1'b0;
  logic [FN_W-1:0] cfg_fn = '0;
  logic [TT_W-1:0] cfg_tt = '0;
  logic            cfg_ready;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N_IN-1:0] in_x = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [N_FN-1:0] out_s;
  logic            sweep_start = 1'b0;
  logic            sweep_busy;
  logic            sweep_valid;
  logic [N_IN-1:0] sweep_idx;
  logic [N_FN-1:0] sweep_s;
  logic            sweep_done;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected fn0 column for TT_Q01, written out by hand from its minterm list.
  int ROW0 [16] = '{0,0,1,1,1,1,0,0,0,0,1,1,0,1,0,1};

  always #5 clk = ~clk;

  lut_eval_sweep #(.N_IN(N_IN), .N_FN(N_FN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_fn      (cfg_fn),
    .cfg_tt      (cfg_tt),
    .cfg_ready   (cfg_ready),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_s       (out_s),
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy),
    .sweep_valid (sweep_valid),
    .sweep_idx   (sweep_idx),
    .sweep_s     (sweep_s),
    .sweep_done  (sweep_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  logic [TT_W-1:0] m_tt [N_FN];
  bit              m_valid = 1'b0;
  logic [N_FN-1:0] m_s = '0;
  int              m_sc = -1;  // -1 idle; 0 started; 1..16 row sc-1 shown; 17 done shown

  initial for (int f = 0; f < N_FN; f++) m_tt[f] = '0;

  function automatic logic [N_FN-1:0] m_lookup(input logic [N_IN-1:0] x);
    logic [N_FN-1:0] r;
    for (int f = 0; f < N_FN; f++) r[f] = m_tt[f][x];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int f = 0; f < N_FN; f++) m_tt[f] = '0;
      m_valid = 1'b0;
      m_s     = '0;
      m_sc    = -1;
    end else begin
      bit rdy;
      bit busy;
      rdy  = !m_valid || out_ready;
      busy = (m_sc >= 0);
      if (in_valid && rdy) begin
        m_s     = m_lookup(in_x);
        m_valid = 1'b1;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      if (cfg_we && !busy && (int'(cfg_fn) < N_FN)) m_tt[cfg_fn] = cfg_tt;
      if (m_sc >= 0) m_sc = (m_sc >= 17) ? -1 : m_sc + 1;
      else if (SW_EN && sweep_start) m_sc = 0;
    end
  end

  // ---------------------------------------------------------------- per-cycle compare
  always @(negedge clk) begin
    logic            e_busy;
    logic            e_sv;
    logic [N_IN-1:0] e_si;
    logic [N_FN-1:0] e_ss;
    e_busy = (m_sc >= 0);
    e_sv   = (m_sc >= 1) && (m_sc <= 16);
    e_si   = e_sv ? N_IN'(m_sc - 1) : '0;
    e_ss   = e_sv ? m_lookup(e_si) : '0;
    chk("out_valid",   out_valid,   m_valid);
    chk("out_s",       out_s,       m_s);
    chk("in_ready",    in_ready,    !m_valid || out_ready);
    chk("cfg_ready",   cfg_ready,   !e_busy);
    chk("sweep_busy",  sweep_busy,  e_busy);
    chk("sweep_valid", sweep_valid, e_sv);
    chk("sweep_idx",   sweep_idx,   e_si);
    chk("sweep_s",     sweep_s,     e_ss);
    chk("sweep_done",  sweep_done,  m_sc == 17);
  end

  // ---------------------------------------------------------------- stimulus
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int fn, input logic [TT_W-1:0] tt);
    cfg_we = 1'b1;
    cfg_fn = FN_W'(fn);
    cfg_tt = tt;
    step();
    cfg_we = 1'b0;
    $display("[TB] write fn%0d tt=%h", fn, tt);
  endtask

  task automatic eval1(input int x, output logic [N_FN-1:0] s);
    in_valid  = 1'b1;
    in_x      = N_IN'(x);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("eval1_valid", out_valid, 1'b1);
    s = out_s;
    $display("[TB] eval x=%0d s=%b", x, s);
  endtask

  initial begin
    logic [N_FN-1:0] s;
    logic [N_FN-1:0] r;
    int rows;
    int dones;
    bit found;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid",   out_valid,   1'b0);
    chk("rst_out_s",       out_s,       2'b00);
    chk("rst_sweep_busy",  sweep_busy,  1'b0);
    chk("rst_sweep_valid", sweep_valid, 1'b0);
    chk("rst_sweep_idx",   sweep_idx,   4'd0);
    chk("rst_sweep_s",     sweep_s,     2'b00);
    chk("rst_sweep_done",  sweep_done,  1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    eval1(3, s);
    chk("t1_s_zero", s, 2'b00);
    step();

    wr(0, TT_Q01);
    wr(1, 16'h8000);
    for (int i = 0; i < 16; i++) begin
      r = m_lookup(N_IN'(i));
      chk("model_row0", r[0], ROW0[i]);
      chk("model_row1", r[1], i == 15);
    end

    // stream all codes at full throughput
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      in_x     = N_IN'(k);
      step();
      chk("stream_valid", out_valid, 1'b1);
      chk("stream_fn0", out_s[0], ROW0[k]);
      if (k == 15) chk("stream_x15", out_s, 2'b11);
      if (k == 3)  chk("stream_x3",  out_s, 2'b01);
      if (k == 0)  chk("stream_x0",  out_s, 2'b00);
    end
    in_valid = 1'b0;
    step();

    // backpressure
    in_valid = 1'b1;
    in_x     = 4'd5;
    step();
    chk("bp_first", out_s, 2'b01);
    out_ready = 1'b0;
    in_x      = 4'd6;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_hold_s", out_s, 2'b01);
      chk("bp_hold_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("bp_release_s", out_s, 2'b00);
    chk("bp_release_valid", out_valid, 1'b1);
    step();
    chk("bp_no_dup", out_valid, 1'b0);

    // write and accept in the same cycle
    in_valid = 1'b1;
    in_x     = 4'd2;
    cfg_we   = 1'b1;
    cfg_fn   = '0;
    cfg_tt   = '0;
    step();
    cfg_we = 1'b0;
    chk("wa_old_table", out_s[0], 1'b1);
    step();
    in_valid = 1'b0;
    chk("wa_new_table", out_s[0], 1'b0);
    step();
    wr(0, TT_Q01);

`ifdef LUT_SWEEP_EN
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    rows  = 0;
    dones = 0;
    for (int c = 0; c < 30; c++) begin
      cfg_we      = (c == 3);
      cfg_fn      = '0;
      cfg_tt      = '0;
      sweep_start = (c == 3);
      step();
      if (sweep_valid) begin
        if (rows < 16) begin
          chk("sw_idx", sweep_idx, rows);
          chk("sw_row", sweep_s[0], ROW0[rows]);
        end
        rows++;
      end
      if (sweep_done) begin
        chk("sw_done_after_last", rows, 16);
        dones++;
      end
    end
    cfg_we      = 1'b0;
    sweep_start = 1'b0;
    $display("[TB] sweep rows=%0d dones=%0d", rows, dones);
    chk("sw_rows", rows, 16);
    chk("sw_dones", dones, 1);
    eval1(2, s);
    chk("sw_write_dropped", s[0], 1'b1);

    // reset mid-sweep
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (sweep_valid && sweep_idx == 4'd7) begin
        found = 1'b1;
        break;
      end
    end
    chk("sw_reach_idx7", found, 1'b1);
`else
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    chk("nosw_busy", sweep_busy, 1'b0);
    chk("nosw_cfg_ready", cfg_ready, 1'b1);
    wr(0, 16'h0000);
    eval1(2, s);
    chk("nosw_write_taken", s[0], 1'b0);
    wr(0, TT_Q01);
`endif

    rst_n = 1'b0;
    #1;
    chk("ar_busy", sweep_busy, 1'b0);
    chk("ar_valid", sweep_valid, 1'b0);
    chk("ar_done", sweep_done, 1'b0);
    chk("ar_out_valid", out_valid, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    eval1(2, s);
    chk("ar_tables_x2", s, 2'b00);
    eval1(15, s);
    chk("ar_tables_x15", s, 2'b00);
    step();

    // randomized traffic, checked by the per-cycle compare
    for (int c = 0; c < 600; c++) begin
      in_valid    = 1'($urandom_range(0, 1));
      in_x        = N_IN'($urandom);
      out_ready   = ($urandom_range(0, 9) < 7);
      cfg_we      = ($urandom_range(0, 9) == 0);
      cfg_fn      = FN_W'($urandom);
      cfg_tt      = TT_W'($urandom);
      sweep_start = ($urandom_range(0, 29) == 0);
      step();
    end
    in_valid    = 1'b0;
    cfg_we      = 1'b0;
    sweep_start = 1'b0;
    out_ready   = 1'b1;
    repeat (25) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
